s27_seq_ctrl: RTL

S27_SEQ_CTRL -- requirements
Module: s27_seq_ctrl

---
 rtl/s27_seq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/s27_seq_ctrl.sv
// s27_seq_ctrl -- handshake controller around the ISCAS s27 sequential core.
// A vector is accepted in IDLE, applied in_rep+1 times (one application per
// cycle in EVAL), and the final G17 plus the resulting {G7,G6,G5} state are
// presented in RESP until the consumer takes them.
// Optional build macro S27_SEQ_SCAN_EN adds a 3-bit scan chain through the
// state registers (scan_en / scan_in / scan_out), usable only while IDLE.
module s27_seq_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_vec,
    input  logic [3:0] in_rep,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_g17,
    output logic [2:0] out_state,
    output logic [7:0] resp_cnt
`ifdef S27_SEQ_SCAN_EN
    ,
    input  logic       scan_en,
    input  logic       scan_in,
    output logic       scan_out
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_reg;

    // s27 state flops and the captured vector / repetition count
    logic       g5_reg;
    logic       g6_reg;
    logic       g7_reg;
    logic [3:0] vec_reg;
    logic [3:0] rep_reg;

    // registered response
    logic       out_valid_reg;
    logic       out_g17_reg;
    logic [2:0] out_state_reg;
    logic [7:0] resp_cnt_reg;

    // core combinational network, evaluated on the captured vector
    logic       n14;
    logic       n15;
    logic       n16;
    logic       n18;
    logic       n11;
    logic       n21;
    logic       g1_g7_low;
    logic       g6_g0_low;
    logic       g17_next;
    logic       g5_next;
    logic       g6_next;
    logic       g7_next;

    // scan control; tied off when the scan chain is not built
    logic       scan_shift;
    logic       scan_bit;

    assign n14       = ~vec_reg[0];
    assign g6_g0_low = g6_reg & n14;
    assign g1_g7_low = ~vec_reg[1] & ~g7_reg;
    assign n15       = ~(g6_g0_low | vec_reg[3]);
    assign n18       = ~(g6_g0_low | g1_g7_low);
    assign g17_next  = n18 | g5_reg | n15;
    assign n16       = ~(n18 | n15 | g5_reg);
    assign n11       = ~(n16 | n14);
    assign n21       = ~(g1_g7_low | vec_reg[2]);

    assign g5_next   = n11;
    assign g6_next   = n16;
    assign g7_next   = n21;

`ifdef S27_SEQ_SCAN_EN
    // scan only takes effect while idle; elsewhere scan_en is ignored
    assign scan_shift = scan_en && (state_reg == IDLE);
    assign scan_bit   = scan_in;
    assign scan_out   = g7_reg;
`else
    assign scan_shift = 1'b0;
    assign scan_bit   = 1'b0;
`endif

    // ready is a pure decode of the state, suppressed while shifting
    assign in_ready  = (state_reg == IDLE) && !scan_shift;

    assign out_valid = out_valid_reg;
    assign out_g17   = out_g17_reg;
    assign out_state = out_state_reg;
    assign resp_cnt  = resp_cnt_reg;

    // controller FSM: accept, repeat applications, hold response until taken
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            g5_reg        <= 1'b0;
            g6_reg        <= 1'b0;
            g7_reg        <= 1'b0;
            vec_reg       <= 4'd0;
            rep_reg       <= 4'd0;
            out_valid_reg <= 1'b0;
            out_g17_reg   <= 1'b0;
            out_state_reg <= 3'd0;
            resp_cnt_reg  <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (scan_shift) begin
                        // shift toward G7; G7 is the chain output
                        g5_reg <= scan_bit;
                        g6_reg <= g5_reg;
                        g7_reg <= g6_reg;
                    end else if (in_valid) begin
                        vec_reg   <= in_vec;
                        rep_reg   <= in_rep;
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    // one application per cycle; G17 uses the pre-update state
                    g5_reg <= g5_next;
                    g6_reg <= g6_next;
                    g7_reg <= g7_next;
                    if (rep_reg == 4'd0) begin
                        out_g17_reg   <= g17_next;
                        out_state_reg <= {g7_next, g6_next, g5_next};
                        out_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        rep_reg <= rep_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        resp_cnt_reg  <= resp_cnt_reg + 8'd1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
